// File: rtl/ibus_fetch_bridge_pkg.sv
// Shared bus definitions for the instruction-fetch path.
// Provides the CPU fetch request/response structs, the memory-side
// request/response structs, transfer size/length encodings and burst codes.
package ibus_fetch_bridge_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Beat count minus one, AXI style
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/ibus_fetch_bridge.sv
// ibus_fetch_bridge: bridges CPU instruction fetches onto the memory bus
// through a one-entry line buffer holding a single aligned doubleword.
// Ports:
//   clk    - clock, all state updates on posedge
//   resetn - asynchronous active-low reset
//   ireq   - CPU fetch request (valid, addr)
//   iresp  - CPU fetch response (addr_ok, data_ok, data); combinational on hit
//   creq   - memory-side read request, held stable while fetching
//   cresp  - memory-side response (ready, last, data)
//   flush  - invalidates the line buffer (fence.i / redirect)
module ibus_fetch_bridge
  import ibus_fetch_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  input  logic       flush
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        buf_valid;
  logic [60:0] buf_tag;
  logic [63:0] buf_data;
  logic [60:0] fetch_tag;
  logic        flush_pending;
  logic        hit;
  logic        fill_done;

  // Byte offset within the word is meaningless for 32-bit instruction fetch
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, ireq.addr[1:0]};

  // Hit detection, next-state selection and response/request generation
  always_comb begin
    hit        = 1'b0;
    fill_done  = 1'b0;
    next_state = state;
    iresp      = '0;
    creq       = '0;

    hit = (state == IDLE) && ireq.valid && buf_valid &&
          (ireq.addr[63:3] == buf_tag) && !flush;
    fill_done = (state == FETCH) && cresp.ready && cresp.last;

    case (state)
      IDLE: begin
        if (ireq.valid && !hit && !flush) begin
          next_state = FETCH;
        end else begin
          next_state = IDLE;
        end
      end
      FETCH: begin
        // A redirect of ireq.addr does not abort the bus transaction
        if (fill_done) begin
          next_state = IDLE;
        end else begin
          next_state = FETCH;
        end
      end
      default: next_state = IDLE;
    endcase

    if (hit) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = ireq.addr[2] ? buf_data[63:32] : buf_data[31:0];
    end else begin
      iresp = '0;
    end

    if (state == FETCH) begin
      creq.valid    = 1'b1;
      creq.is_write = 1'b0;
      creq.size     = MSIZE8;
      creq.addr     = {fetch_tag, 3'b000};
      creq.strobe   = 8'h00;
      creq.data     = 64'h0;
      creq.len      = MLEN1;
      creq.burst    = AXI_BURST_FIXED;
    end else begin
      creq = '0;
    end
  end

  // State register, line buffer, fetch address and pending-flush tracking
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      buf_valid     <= 1'b0;
      buf_tag       <= 61'h0;
      buf_data      <= 64'h0;
      fetch_tag     <= 61'h0;
      flush_pending <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          flush_pending <= 1'b0;
          if (flush) begin
            buf_valid <= 1'b0;
          end
          if (next_state == FETCH) begin
            fetch_tag <= ireq.addr[63:3];
          end
        end
        FETCH: begin
          if (fill_done) begin
            buf_data      <= cresp.data;
            buf_tag       <= fetch_tag;
            // A flush seen at any point of the fetch leaves the data unusable
            buf_valid     <= !(flush || flush_pending);
            flush_pending <= 1'b0;
          end else if (flush) begin
            flush_pending <= 1'b1;
          end
        end
        default: begin
          flush_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibus_fetch_bridge.sv
// Self-checking bench for ibus_fetch_bridge: directed scenarios plus a
// randomized run, all checked cycle by cycle against a transaction-level
// model of the line buffer and the single outstanding memory read.
module tb_ibus_fetch_bridge;
  import ibus_fetch_bridge_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       flush;

  int checks = 0;
  int failures = 0;

  // Reference model: the cached line and the outstanding read, if any
  bit          line_valid;
  logic [60:0] line_tag;
  logic [63:0] line_data;
  bit          outstanding;
  logic [60:0] out_tag;
  bit          poisoned;

  ibus_resp_t obs_iresp;
  cbus_req_t  obs_creq;

  ibus_fetch_bridge dut (
    .clk    (clk),
    .resetn (resetn),
    .ireq   (ireq),
    .iresp  (iresp),
    .creq   (creq),
    .cresp  (cresp),
    .flush  (flush)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    line_valid  = 1'b0;
    line_tag    = 61'h0;
    line_data   = 64'h0;
    outstanding = 1'b0;
    out_tag     = 61'h0;
    poisoned    = 1'b0;
  endtask

  // One clock cycle: apply inputs, check outputs at negedge, advance model
  task automatic step(input logic v, input logic [63:0] a, input logic fl,
                      input logic rdy, input logic lst, input logic [63:0] d);
    ibus_resp_t exp_r;
    cbus_req_t  exp_c;
    bit         will_hit;
    ireq.valid  = v;
    ireq.addr   = a;
    flush       = fl;
    cresp.ready = rdy;
    cresp.last  = lst;
    cresp.data  = d;
    @(negedge clk);
    will_hit = !outstanding && v && line_valid && (a[63:3] == line_tag) && !fl;
    exp_r = '0;
    if (will_hit) begin
      exp_r.addr_ok = 1'b1;
      exp_r.data_ok = 1'b1;
      exp_r.data    = a[2] ? line_data[63:32] : line_data[31:0];
    end
    exp_c = '0;
    if (outstanding) begin
      exp_c.valid = 1'b1;
      exp_c.size  = MSIZE8;
      exp_c.addr  = {out_tag, 3'b000};
      exp_c.len   = MLEN1;
      exp_c.burst = AXI_BURST_FIXED;
    end
    obs_iresp = iresp;
    obs_creq  = creq;
    checks++;
    if (iresp !== exp_r) begin
      failures++;
      $display("FAIL iresp t=%0t addr=%h got=%h want=%h", $time, a, iresp, exp_r);
    end
    checks++;
    if (creq !== exp_c) begin
      failures++;
      $display("FAIL creq t=%0t got=%h want=%h", $time, creq, exp_c);
    end
    if (!outstanding) begin
      if (fl) line_valid = 1'b0;
      if (v && !will_hit && !fl) begin
        outstanding = 1'b1;
        out_tag     = a[63:3];
        poisoned    = 1'b0;
      end
    end else begin
      if (fl) poisoned = 1'b1;
      if (rdy && lst) begin
        line_valid  = !poisoned;
        line_tag    = out_tag;
        line_data   = d;
        outstanding = 1'b0;
        poisoned    = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    ireq  = '{valid: 1'b1, addr: 64'h8000_0000};
    cresp = '{ready: 1'b1, last: 1'b1, data: 64'hDEAD_BEEF_0000_0001};
    flush = 1'b0;
    resetn = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (iresp !== '0) begin
        failures++;
        $display("FAIL reset_iresp got=%h want=0", iresp);
      end
      checks++;
      if (creq !== '0) begin
        failures++;
        $display("FAIL reset_creq got=%h want=0", creq);
      end
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_cold_miss_and_hit();
    do_reset();
    step(1'b1, 64'h8000_0004, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 64'h8000_0004, 1'b0, 1'b0, 1'b0, 64'h0);
    checks++;
    if (obs_creq.addr !== 64'h8000_0000 || obs_creq.valid !== 1'b1) begin
      failures++;
      $display("FAIL cold_creq got=%h want valid addr 80000000", obs_creq);
    end
    step(1'b1, 64'h8000_0004, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 64'h8000_0004, 1'b0, 1'b1, 1'b1, 64'h1111_2222_3333_4444);
    step(1'b1, 64'h8000_0004, 1'b0, 1'b0, 1'b0, 64'h0);
    checks++;
    if (obs_iresp.data_ok !== 1'b1 || obs_iresp.data !== 32'h1111_2222) begin
      failures++;
      $display("FAIL cold_data got=%h want ok data 11112222", obs_iresp);
    end
    step(1'b1, 64'h8000_0003, 1'b0, 1'b0, 1'b0, 64'h0);
    checks++;
    if (obs_iresp.data !== 32'h3333_4444 || obs_creq.valid !== 1'b0) begin
      failures++;
      $display("FAIL hit_low got=%h creq_valid=%b want 33334444 and 0", obs_iresp, obs_creq.valid);
    end
  endtask

  task automatic test_redirect();
    step(1'b1, 64'h8000_0008, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 64'h8000_1000, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 64'h8000_1000, 1'b0, 1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
    step(1'b1, 64'h8000_000C, 1'b0, 1'b0, 1'b0, 64'h0);
    checks++;
    if (obs_iresp.data !== 32'hAAAA_BBBB) begin
      failures++;
      $display("FAIL redirect_tag got=%h want aaaabbbb", obs_iresp.data);
    end
    step(1'b1, 64'h8000_1000, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 64'h8000_1000, 1'b0, 1'b1, 1'b1, 64'h0102_0304_0506_0708);
    checks++;
    if (obs_creq.addr !== 64'h8000_1000) begin
      failures++;
      $display("FAIL redirect_creq got=%h want 80001000", obs_creq.addr);
    end
    step(1'b1, 64'h8000_1000, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_flush();
    // Flush while idle on a matching address suppresses the hit
    step(1'b1, 64'h8000_1004, 1'b1, 1'b0, 1'b0, 64'h0);
    checks++;
    if (obs_iresp.data_ok !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle got=%b want 0", obs_iresp.data_ok);
    end
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    // Flush one cycle mid-fetch
    step(1'b1, 64'h8000_2000, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 64'h8000_2000, 1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b1, 64'h8000_2000, 1'b0, 1'b1, 1'b1, 64'h5555_6666_7777_8888);
    step(1'b1, 64'h8000_2000, 1'b0, 1'b0, 1'b0, 64'h0);
    checks++;
    if (obs_iresp.data_ok !== 1'b0) begin
      failures++;
      $display("FAIL flush_fetch_hit got=%b want 0", obs_iresp.data_ok);
    end
    step(1'b1, 64'h8000_2000, 1'b0, 1'b1, 1'b1, 64'h5555_6666_7777_8888);
    checks++;
    if (obs_creq.valid !== 1'b1 || obs_creq.addr !== 64'h8000_2000) begin
      failures++;
      $display("FAIL flush_refetch got=%h want valid 80002000", obs_creq);
    end
    step(1'b1, 64'h8000_2000, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_backpressure();
    step(1'b1, 64'h8000_3000, 1'b0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 64'h8000_3000, 1'b0, 1'b0, 1'b1, 64'h0);
      checks++;
      if (obs_iresp.data_ok !== 1'b0 || obs_creq.addr !== 64'h8000_3000) begin
        failures++;
        $display("FAIL backpressure cyc=%0d iresp=%h creq_addr=%h", i, obs_iresp, obs_creq.addr);
      end
    end
    step(1'b1, 64'h8000_3000, 1'b0, 1'b1, 1'b1, 64'h9999_0000_9999_0001);
    step(1'b1, 64'h8000_3000, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_async_reset();
    step(1'b1, 64'h8000_0000, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 64'h8000_0000, 1'b0, 1'b0, 1'b0, 64'h0);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (creq !== '0 || iresp !== '0) begin
      failures++;
      $display("FAIL async_reset creq=%h iresp=%h want 0", creq, iresp);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step(1'b1, 64'h8000_0000, 1'b0, 1'b0, 1'b0, 64'h0);
    checks++;
    if (obs_iresp.data_ok !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_miss got=%b want 0", obs_iresp.data_ok);
    end
    step(1'b1, 64'h8000_0000, 1'b0, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0);
    step(1'b1, 64'h8000_0000, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_random();
    logic [63:0] bases [4];
    logic [63:0] a;
    logic        v, fl, rdy, lst;
    bases[0] = 64'h8000_0000;
    bases[1] = 64'h8000_0008;
    bases[2] = 64'h8000_1000;
    bases[3] = 64'hFFFF_FFFF_FFFF_FFF8;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0)
        a = {$urandom(), $urandom()};
      else
        a = bases[$urandom_range(0, 3)] | 64'($urandom_range(0, 7));
      v  = ($urandom_range(0, 4) != 0);
      fl = ($urandom_range(0, 19) == 0);
      if (outstanding) begin
        rdy = ($urandom_range(0, 2) == 0);
        lst = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = $urandom_range(0, 1) == 1;
        lst = $urandom_range(0, 1) == 1;
      end
      step(v, a, fl, rdy, lst, {$urandom(), $urandom()});
    end
  endtask

  initial begin
    ireq  = '0;
    cresp = '0;
    flush = 1'b0;
    model_reset();
    test_reset();
    test_cold_miss_and_hit();
    test_redirect();
    test_flush();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
